// File: rtl/rf_write_arbiter.sv
// Single write port arbiter for the RV32I register file: ALU writeback, buffered
// load results and debug writes share one registered write slot per cycle.
module rf_write_arbiter #(
    parameter int LD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_rd_data,
    output logic [31:0] pend_mask
);
    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(LD_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_DBG, SRC_FIFO} src_e;

    logic [4:0]          fifo_addr [LD_DEPTH];
    logic [31:0]         fifo_data [LD_DEPTH];
    logic [LD_DEPTH-1:0] fifo_vld;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PW:0]         count;
    logic [SW-1:0]       starve_cnt;

    src_e        win;
    logic [4:0]  win_addr;
    logic [31:0] win_data;
    logic        push, pop, starve_hit;

    assign starve_hit = (starve_cnt == LIMIT_C);

    always_comb begin
        win = SRC_NONE;
        if (alu_valid && alu_addr != 5'd0)  win = SRC_ALU;
        else if (dbg_valid && starve_hit)   win = SRC_DBG;
        else if (count != '0)               win = SRC_FIFO;
        else if (dbg_valid)                 win = SRC_DBG;
    end

    always_comb begin
        win_addr = 5'd0;
        win_data = 32'd0;
        case (win)
            SRC_ALU:  begin win_addr = alu_addr;          win_data = alu_data;          end
            SRC_DBG:  begin win_addr = dbg_addr;          win_data = dbg_data;          end
            SRC_FIFO: begin win_addr = fifo_addr[rd_ptr]; win_data = fifo_data[rd_ptr]; end
            default:  ;
        endcase
    end

    // No pop bypass: a full FIFO refuses a load even in the cycle its head drains.
    assign ld_ready  = !sysreset && (count < DEPTH_C);
    assign dbg_ready = !sysreset && (win == SRC_DBG);
    // Loads to x0 complete the handshake but are never stored.
    assign push      = ld_valid && ld_ready && (ld_addr != 5'd0);
    assign pop       = (win == SRC_FIFO);

    always_ff @(posedge sysclk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ld_addr;
            fifo_data[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            fifo_vld   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_rd_addr <= 5'd0;
            rf_rd_data <= 32'd0;
        end else begin
            if (push) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (!dbg_valid || dbg_ready)  starve_cnt <= '0;
            else if (!starve_hit)         starve_cnt <= starve_cnt + 1'b1;

            // A debug grant to x0 consumes the slot but leaves address/data held.
            rf_we <= (win != SRC_NONE) && (win_addr != 5'd0);
            if (win != SRC_NONE && win_addr != 5'd0) begin
                rf_rd_addr <= win_addr;
                rf_rd_data <= win_data;
            end
        end
    end

    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (fifo_vld[i]) pend_mask[fifo_addr[i]] = 1'b1;
        if (rf_we) pend_mask[rf_rd_addr] = 1'b1;
        pend_mask[0] = 1'b0;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Owns the single write port of the RV32I register file and shares it between three requesters: ALU writeback, the multi-cycle load unit and the debug module. ALU writeback has absolute priority and no backpressure. Load results are buffered in a small FIFO. Debug writes use a valid/ready handshake with a starvation guard. The block also exports a pending-write mask that the hazard unit uses to stall issue on WAW/RAW against buffered loads.

Parameters:
LD_DEPTH, 2, load-result FIFO depth in entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles after which debug outranks the load FIFO (>=1)

Ports:
sysclk  input  1  system clock
sysreset  input  1  synchronous reset, active-high
alu_valid  input  1  ALU writeback request this cycle, never stalled
alu_addr  input  5  ALU destination register
alu_data  input  32  ALU result
ld_valid  input  1  load result offered
ld_ready  output  1  FIFO can accept a load result
ld_addr  input  5  load destination register
ld_data  input  32  load result
dbg_valid  input  1  debug write request, held until granted
dbg_ready  output  1  debug grant, single-cycle pulse
dbg_addr  input  5  debug destination register
dbg_data  input  32  debug write data
rf_we  output  1  register file write enable, registered
rf_rd_addr  output  5  register file write address, registered
rf_rd_data  output  32  register file write data, registered
pend_mask  output  32  bit i set while a write to xi is buffered or staged

Behaviour:
- Reset (sysreset high at a rising sysclk edge): FIFO emptied and its contents discarded; starvation counter cleared; rf_we, rf_rd_addr, rf_rd_data and pend_mask all 0. While sysreset is high, ld_ready=0 and dbg_ready=0. Reset mid-operation drops all buffered loads with no write.
- Arbitration is combinational in cycle N. The winner is registered onto rf_* and driven during cycle N+1, so the register file is updated at the end of N+1. One write per cycle.
- Priority, evaluated in order:
  1. alu_valid with alu_addr!=0.
  2. dbg_valid when starve_hit.
  3. FIFO head, if the FIFO is non-empty.
  4. dbg_valid.
- An ALU request to x0 counts as no request, so the slot goes to a lower-priority requester.
- If no winner: rf_we=0 next cycle; rf_rd_addr and rf_rd_data hold their previous values.
- Load FIFO:
  - Push when ld_valid && ld_ready. ld_ready = (count < LD_DEPTH), with no same-cycle pop bypass.
  - A load with ld_addr=0 is accepted (handshake completes) but not stored.
  - A pushed entry becomes eligible for arbitration the cycle after the push.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pop occurs only when the head wins. Entries drain in order.
  - Count never exceeds LD_DEPTH and never underflows.
- Debug:
  - dbg_ready=1 in the cycle debug wins. The requester drops or changes its request after that cycle.
  - If dbg_addr=0: grant is issued, rf_we stays 0.
- Starvation counter:
  - Increments in cycles where dbg_valid=1 and dbg_ready=0, saturating at STARVE_LIMIT.
  - Clears on grant or when dbg_valid=0.
  - starve_hit = (counter == STARVE_LIMIT).
  - Debug never outranks the ALU, so starvation is bounded only when the ALU is idle.
- pend_mask: bit i = 1 if any valid FIFO entry targets xi, or if rf_we=1 with rf_rd_addr=i. Bit 0 is always 0. pend_mask is combinational from state; there is no same-cycle contribution from ld_* inputs.
- Ordering: the block does not resolve WAW between the ALU and older buffered loads. The hazard unit stalls any issue whose rd or rs has its pend_mask bit set.

Test Plan:
1. After reset, single ALU write: alu_valid=1, addr=5, data=0xDEADBEEF in cycle N -> rf_we=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF in N+1; rf_we=0 in N+2; pend_mask[5]=1 only in N+1.
2. Load under ALU pressure: push loads to x3 and x4 while the ALU writes every cycle -> ld_ready=0 after 2 pushes; pend_mask=0x18; once the ALU idles, x3 then x4 are written on consecutive cycles; pend_mask returns to 0.
3. x0 filtering: ALU to x0 together with FIFO head x7 -> x7 written next cycle. Load to x0 -> accepted, FIFO count unchanged, no write. Debug to x0 -> dbg_ready pulse, rf_we=0.
4. Starvation: FIFO kept non-empty with the ALU idle and dbg_valid held -> dbg_ready asserts after exactly STARVE_LIMIT=8 blocked cycles, ahead of the FIFO head. Counter is 0 the next cycle.
5. Simultaneous push and pop: FIFO full (2 entries), head wins and a new load is offered -> ld_ready=0, so no push. With 1 entry, push and pop in the same cycle -> count stays 1, and data order is preserved.
6. Reset mid-operation: 2 buffered loads and a pending debug request, then sysreset for 1 cycle -> pend_mask=0, rf_we=0, no buffered load is ever written, and dbg_ready=0 during reset.
